// File: rtl/counter_arb_pkg.sv
// Shared types and default sizing for the counter arbiter.
package counter_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MOD_DEF   = 6;
  localparam int CNT_W_DEF = 3;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up-counter: clr forces zero, en advances and wraps at MOD-1, tc flags MOD-1.
module mod_counter
  import counter_arb_pkg::*;
#(
  parameter int MOD   = MOD_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] q,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MOD - 1);

  assign tc = (q == LAST);

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= tc ? '0 : q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin arbiter lending one shared modulo counter to N_REQ requesters for MOD cycles each.
// Optional feature: define CNT_ARB_ABORT_EN to let a requester abort its run by dropping req.
module counter_arbiter
  import counter_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int MOD   = MOD_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [CNT_W-1:0] q,
  output logic             busy,
  output logic [N_REQ-1:0] done,
  output logic             abort
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] win_inc;
  logic [PTR_W-1:0] rr_win;
  logic [PTR_W-1:0] scan_idx;
  logic             rr_any;
  logic             tc;
  logic             run_end;
  logic             drop;
  int               scan;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    rr_any   = 1'b0;
    rr_win   = ptr;
    scan     = 0;
    scan_idx = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      scan = int'(ptr) + i;
      if (scan >= N_REQ) scan = scan - N_REQ;
      scan_idx = PTR_W'(scan);
      if (!rr_any && req[scan_idx]) begin
        rr_any = 1'b1;
        rr_win = scan_idx;
      end
    end
  end

  assign win_inc = (win == PTR_W'(N_REQ - 1)) ? '0 : win + PTR_W'(1);
  assign run_end = (state == RUN) && tc;
  assign busy    = (state == RUN);

`ifdef CNT_ARB_ABORT_EN
  // Completion on the final cycle wins over a late drop of the granted request.
  assign drop = (state == RUN) && !req[win] && !tc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) abort <= 1'b0;
    else       abort <= drop;
  end
`else
  assign drop  = 1'b0;
  assign abort = 1'b0;
`endif

  mod_counter #(
    .MOD   (MOD),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   ((state == IDLE) || drop),
    .en    (state == RUN),
    .q     (q),
    .tc    (tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      win   <= '0;
      gnt   <= '0;
      done  <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (rr_any) begin
            state <= RUN;
            win   <= rr_win;
            gnt   <= N_REQ'(1) << rr_win;
          end
        end
        RUN: begin
          if (run_end || drop) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= win_inc;
            if (run_end) done <= N_REQ'(1) << win;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// Scoreboard bench for counter_arbiter (N_REQ=4, MOD=6): expected cycles queued with stimulus.
module tb_counter_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [2:0] q;
  logic       busy;
  logic [3:0] done;
  logic       abort;

  typedef struct packed {
    logic [3:0] gnt;
    logic [2:0] q;
    logic       busy;
    logic [3:0] done;
    logic       abort;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  counter_arbiter #(.N_REQ(4), .MOD(6), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .gnt   (gnt),
    .q     (q),
    .busy  (busy),
    .done  (done),
    .abort (abort)
  );

  always #5 clk = ~clk;

  function automatic exp_t observe();
    exp_t o;
    o.gnt   = gnt;
    o.q     = q;
    o.busy  = busy;
    o.done  = done;
    o.abort = abort;
    return o;
  endfunction

  task automatic push(input logic [3:0] g, input int qv, input logic b,
                      input logic [3:0] d, input logic a);
    exp_t e;
    e.gnt   = g;
    e.q     = 3'(qv);
    e.busy  = b;
    e.done  = d;
    e.abort = a;
    sb.push_back(e);
  endtask

  task automatic push_run(input logic [3:0] g, input int from, input int to);
    for (int i = from; i <= to; i++) push(g, i, 1'b1, 4'b0000, 1'b0);
  endtask

  task automatic report(input string name, input int cyc, input exp_t o, input exp_t e);
    $display("FAIL %s cyc %0d: got gnt=%b q=%0d busy=%b done=%b abort=%b, want gnt=%b q=%0d busy=%b done=%b abort=%b",
             name, cyc, o.gnt, o.q, o.busy, o.done, o.abort, e.gnt, e.q, e.busy, e.done, e.abort);
  endtask

  task automatic test_reset();
    exp_t o;
    reset = 1'b1;
    req   = 4'b1111;
    @(negedge clk);
    o = observe();
    n_cmp++;
    if (o !== exp_t'('0)) begin
      n_err++;
      report("reset_hold", 0, o, exp_t'('0));
    end
    #2;
    reset = 1'b0;
    req   = 4'b0001;
  endtask

  task automatic test_single();
    exp_t e, o;
    int   n = 0;
    push_run(4'b0001, 0, 5);
    push(4'b0000, 0, 1'b0, 4'b0001, 1'b0);
    push(4'b0000, 0, 1'b0, 4'b0000, 1'b0);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        report("single", n, o, e);
      end
      if (n == 6) req = 4'b0000;
      n++;
    end
  endtask

  task automatic test_priority();
    exp_t e, o;
    int   n = 0;
    req = 4'b0101;
    push_run(4'b0100, 0, 5);
    push(4'b0000, 0, 1'b0, 4'b0100, 1'b0);
    push_run(4'b0001, 0, 5);
    push(4'b0000, 0, 1'b0, 4'b0001, 1'b0);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        report("priority", n, o, e);
      end
      n++;
    end
    req = 4'b0000;
  endtask

  task automatic test_async_reset();
    exp_t e, o;
    int   n = 0;
    req = 4'b0010;
    push_run(4'b0010, 0, 3);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        report("async_reset", n, o, e);
      end
      if (n == 3) begin
        #2;
        reset = 1'b1;
        #1;
        o = observe();
        n_cmp++;
        if (o !== exp_t'('0)) begin
          n_err++;
          report("async_reset_now", n, o, exp_t'('0));
        end
        req = 4'b0000;
        push(4'b0000, 0, 1'b0, 4'b0000, 1'b0);
        push(4'b0000, 0, 1'b0, 4'b0000, 1'b0);
      end
      if (n == 4) reset = 1'b0;
      n++;
    end
  endtask

  task automatic test_round_robin();
    exp_t       e, o;
    int         n = 0;
    logic [3:0] order [5];
    order[0] = 4'b0001;
    order[1] = 4'b0010;
    order[2] = 4'b0100;
    order[3] = 4'b1000;
    order[4] = 4'b0001;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      push_run(order[k], 0, 5);
      push(4'b0000, 0, 1'b0, order[k], 1'b0);
    end
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        report("round_robin", n, o, e);
      end
      n++;
    end
    req = 4'b0000;
  endtask

  task automatic test_back_to_back();
    exp_t e, o;
    int   n = 0;
    req = 4'b0001;
    push_run(4'b0001, 0, 5);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        report("back_to_back", n, o, e);
      end
      if (n == 5) begin
        req = 4'b0010;
        push(4'b0000, 0, 1'b0, 4'b0001, 1'b0);
        push_run(4'b0010, 0, 5);
        push(4'b0000, 0, 1'b0, 4'b0010, 1'b0);
      end
      n++;
    end
    req = 4'b0000;
  endtask

  task automatic test_abort();
    exp_t e, o;
    int   n = 0;
    req = 4'b0001;
    push_run(4'b0001, 0, 2);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        report("abort", n, o, e);
      end
      if (n == 2) begin
        req = 4'b0000;
`ifdef CNT_ARB_ABORT_EN
        push(4'b0000, 0, 1'b0, 4'b0000, 1'b1);
`else
        push_run(4'b0001, 3, 5);
        push(4'b0000, 0, 1'b0, 4'b0001, 1'b0);
`endif
        push(4'b0000, 0, 1'b0, 4'b0000, 1'b0);
      end
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_async_reset();
    test_round_robin();
    test_back_to_back();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/counter_arbiter.md
COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters, range 2..8.
REQ-002 SHALL have parameter MOD, default 6: modulus of the shared counter, range 2..2^CNT_W.
REQ-003 SHALL have parameter CNT_W, default 3: counter width.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port req, input, N_REQ bits: level request per requester.
REQ-007 SHALL have port gnt, output, N_REQ bits: registered grant, one-hot or zero.
REQ-008 SHALL have port q, output, CNT_W bits: shared counter value, registered.
REQ-009 SHALL have port busy, output, 1 bit: high while the counter is granted.
REQ-010 SHALL have port done, output, N_REQ bits: one-cycle pulse to the requester whose run completed.
REQ-011 SHALL have port abort, output, 1 bit: one-cycle pulse on an aborted run; tied 0 when the macro is absent.

Function
REQ-012 SHALL implement the FSM states IDLE and RUN.
REQ-013 IDLE: at the edge where any req bit is high, SHALL enter RUN, set gnt to the round-robin winner and set q=0.
REQ-014 Round-robin: SHALL search from pointer ptr upward with wrap-around; the first asserted req wins.
REQ-015 RUN: q SHALL increment by 1 per cycle while q<MOD-1.
REQ-016 RUN with q==MOD-1: at the next edge SHALL set q=0, gnt=0, busy=0, done[winner]=1 for one cycle, ptr=(winner+1) mod N_REQ, and state=IDLE.
REQ-017 A granted run SHALL last exactly MOD cycles with gnt high.
REQ-018 Back-to-back grants SHALL be separated by exactly one IDLE cycle.
REQ-019 busy SHALL equal (state==RUN); gnt SHALL be zero in IDLE.
REQ-020 In IDLE, q SHALL hold 0.
REQ-021 A req change by a non-granted requester during RUN SHALL have no effect on the current run.
REQ-022 If req changes in the same cycle as completion, the next IDLE cycle SHALL arbitrate using the req value sampled then.
REQ-023 ptr SHALL advance only on completion or abort, never on an idle cycle.

Reset
REQ-024 While reset is high, SHALL hold: state=IDLE, q=0, gnt=0, busy=0, done=0, abort=0, ptr=0.
REQ-025 Reset asserted mid-run SHALL cancel the run immediately with no done and no abort pulse.
REQ-026 After reset deasserts, the first arbitration SHALL occur at the first rising edge with reset low.

Configuration
REQ-027 Macro CNT_ARB_ABORT_EN defined: if the granted req bit is low at an edge in RUN, SHALL go to IDLE, q=0, gnt=0, abort=1 for one cycle, no done, ptr=(winner+1) mod N_REQ.
REQ-028 Macro CNT_ARB_ABORT_EN undefined: a granted run SHALL always complete all MOD cycles regardless of req, and abort SHALL be constant 0.

Structure
REQ-029 Package counter_arb_pkg SHALL hold the state typedef (IDLE, RUN) and the default constants MOD_DEF=6 and CNT_W_DEF=3.
REQ-030 The counter SHALL be a sub-module mod_counter (ports clk, reset, clr, en, q, tc) with parameters MOD and CNT_W.
REQ-031 The FSM and round-robin logic SHALL sit in counter_arbiter.

Verification
REQ-032 Reset held for 12 ns, then req=0001 -> gnt=0001 for 6 cycles, q=0,1,2,3,4,5, then done=0001 for one cycle, ptr=1.
REQ-033 req=1111 held constant -> grants in order 0001, 0010, 0100, 1000, 0001, each 6 cycles with one idle cycle between.
REQ-034 req=0101 with ptr=1 -> gnt=0100 first, then 0001.
REQ-035 Reset asserted at q=3 -> q=0 and gnt=0 immediately (asynchronously), no done pulse.
REQ-036 With CNT_ARB_ABORT_EN, req[0] dropped at q=2 -> abort=1 for one cycle, gnt=0, q=0; without the macro -> run completes to q=5 and done[0] pulses.
REQ-037 req=0010 raised in the completion cycle of requester 0 -> next grant is 0010 after exactly one idle cycle.
